mdu: RTL and testbench
======================

# mdu

Multi-cycle multiply/divide unit in the EX stage, alongside the ALU and fed by the same A/B operand buses. It executes MIPS mult, multu, div and divu with iterative radix-2 datapaths, holds the architectural HI/LO registers, and services mthi/mtlo. It exposes busy so hazard control can stall dependent mfhi/mflo and new MDU instructions.

## Interface
Parameters:
- none (datapath fixed at 32 bits; iteration count fixed at 32)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock, sampled on rising edge of clk
- A  input  32  operand 1 (dividend / multiplicand, or mthi/mtlo data)
- B  input  32  operand 2 (divisor / multiplier)
- MDUOp  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6–7 reserved
- start  input  1  command valid; sampled only when idle
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse on the cycle after HI/LO are written by a mult/div
- HI  output  32  HI register (product[63:32] / remainder)
- LO  output  32  LO register (product[31:0] / quotient)

## Operation
- States: IDLE, RUN. 5-bit iteration counter cnt.
- IDLE, start=1, MDUOp 0–3: latch A and B into internal registers, or their magnitudes when signed. Record the result-sign flags and the op. Set cnt=0 and go to RUN. busy=1 from the next cycle.
- IDLE, start=1, MDUOp 4: HI<=A at the edge. MDUOp 5: LO<=A at the edge. No busy, no done.
- IDLE, start=1, MDUOp 6/7: no effect.
- RUN, multiply: one shift-add step per edge on a 64-bit accumulator.
- RUN, divide: one restoring shift-subtract step per edge (remainder/quotient register pair).
- At the edge where cnt==31:
  - Apply sign correction, write HI/LO, go to IDLE.
  - busy falls and done=1 for exactly that following cycle.
- Signed rules:
  - Product is the full 64-bit two's-complement result.
  - Quotient truncates toward zero. Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0x00000000.
- Divide by zero (div/divu with B==0): full 32-cycle run, done pulses, HI and LO keep their prior values.
- start while busy (any MDUOp, including mthi/mtlo) is ignored; no queuing.
- A, B and MDUOp may change freely during RUN; only the values at the start edge matter.
- HI/LO change only at mthi/mtlo edges, completion edges and reset.

## Timing
- Reset values: busy=0, done=0, HI=0x00000000, LO=0x00000000, state IDLE, cnt=0.
- Reset during RUN aborts the operation. It takes priority over completion and start on the same edge.
- Start accepted at edge E0 -> busy=1 during cycles E0..E32 (32 cycles) -> HI/LO updated at E32 -> busy=0 and done=1 during E32..E33.
- A new start is accepted at E32 (the edge where busy was high) only if busy is already 0 in the preceding cycle. Back-to-back: the earliest next start edge is E33.
- mthi/mtlo: single edge, zero busy cycles. The written value is visible on HI/LO the cycle after.
- HI/LO outputs are driven directly from registers (no combinational path from A/B).

## Test plan
- multu A=0xFFFFFFFF B=0xFFFFFFFF -> busy exactly 32 cycles, then HI=0xFFFFFFFE, LO=0x00000001, done for 1 cycle.
- mult A=0xFFFFFFFD (-3) B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Then div A=0xFFFFFFF9 (-7) B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu A=7 B=2 -> LO=3, HI=1.
- div A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000, HI=0x00000000, no hang.
- mthi A=0x11, mtlo A=0x22 (HI/LO readable next cycle) -> divu A=5 B=0 -> after 32 cycles done=1, HI=0x11, LO=0x22.
- mult A=2 B=3 started; mtlo A=0xDEAD and multu pulses issued at cycles 5 and 10 of the run are ignored -> HI=0, LO=6 at E32.
- div started; reset at cycle 10 -> next cycle busy=0, done=0, HI=LO=0. A subsequent multu 4×4 gives LO=16 after a fresh 32 cycles.

Source files
------------

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Iterative radix-2: shift-add multiply, restoring shift-subtract divide,
// 32 iterations each. Signed ops run on magnitudes and fix the sign at the end.
module mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDUOp,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  // Multiply: {partial product, multiplier}. Divide: {remainder, quotient}.
  logic [63:0] acc_q;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [31:0] opnd_q;
  logic        is_div_q;
  logic        neg_lo_q;
  logic        neg_hi_q;
  logic        div_zero_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  // Operand preparation at the start edge.
  logic        op_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  // Iteration datapath and final sign correction.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [63:0] div_next;
  logic [63:0] acc_next;
  logic [63:0] mul_fix;
  logic [31:0] rem_fix;
  logic [31:0] quo_fix;
  logic [31:0] hi_res;
  logic [31:0] lo_res;

  // Magnitudes and sign flags of the incoming operands (mult/div are the signed ops).
  always_comb begin
    op_signed = ~MDUOp[0];
    a_neg     = op_signed & A[31];
    b_neg     = op_signed & B[31];
    a_mag     = a_neg ? (32'd0 - A) : A;
    b_mag     = b_neg ? (32'd0 - B) : B;
  end

  // One multiply or divide step plus the sign-corrected result of that step.
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = div_shift - {1'b0, opnd_q};
    // Restoring step: keep the shifted remainder when the trial subtract underflows.
    div_next  = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                             : {div_diff[31:0], acc_q[30:0], 1'b1};
    acc_next  = is_div_q ? div_next : mul_next;
    mul_fix   = neg_lo_q ? (64'd0 - mul_next) : mul_next;
    rem_fix   = neg_hi_q ? (32'd0 - div_next[63:32]) : div_next[63:32];
    quo_fix   = neg_lo_q ? (32'd0 - div_next[31:0]) : div_next[31:0];
    hi_res    = is_div_q ? rem_fix : mul_fix[63:32];
    lo_res    = is_div_q ? quo_fix : mul_fix[31:0];
  end

  // Control FSM, iteration datapath and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 5'd0;
      acc_q      <= 64'd0;
      opnd_q     <= 32'd0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            case (MDUOp)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                is_div_q   <= MDUOp[1];
                opnd_q     <= MDUOp[1] ? b_mag : a_mag;
                acc_q      <= {32'd0, (MDUOp[1] ? a_mag : b_mag)};
                neg_lo_q   <= a_neg ^ b_neg;
                // Remainder follows the dividend; product high half follows the product.
                neg_hi_q   <= MDUOp[1] ? a_neg : (a_neg ^ b_neg);
                div_zero_q <= MDUOp[1] & (B == 32'd0);
                cnt_q      <= 5'd0;
                state_q    <= StRun;
                busy_q     <= 1'b1;
              end
              3'd4:    hi_q <= A;
              3'd5:    lo_q <= A;
              default: ;
            endcase
          end
        end
        StRun: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            // Divide by zero completes normally but leaves HI/LO untouched.
            if (!div_zero_q) begin
              hi_q <= hi_res;
              lo_q <= lo_res;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases plus randomized commands checked
// against an arithmetic reference model of HI/LO.
module tb_mdu;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  MDUOp;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks;
  int errors;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .MDUOp (MDUOp),
    .start (start),
    .busy  (busy),
    .done  (done),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: HI/LO after a completed command, from plain 64-bit arithmetic.
  task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      p;
    logic [63:0] pv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin
        p = sa * sb;
        pv = p;
        m_hi = pv[63:32];
        m_lo = pv[31:0];
      end
      3'd1: begin
        pv = {32'd0, a} * {32'd0, b};
        m_hi = pv[63:32];
        m_lo = pv[31:0];
      end
      3'd2: if (b != 32'd0) begin
        p = sa / sb;
        pv = p;
        m_lo = pv[31:0];
        p = sa % sb;
        pv = p;
        m_hi = pv[31:0];
      end
      3'd3: if (b != 32'd0) begin
        m_lo = a / b;
        m_hi = a % b;
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  // Issue a mult/div command and follow it to completion; inject ignored starts if asked.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit inject);
    int n;
    @(negedge clk);
    MDUOp = op;
    A     = a;
    B     = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    MDUOp = 3'($urandom_range(0, 7));
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      start = 1'b0;
      if (inject && n == 5) begin
        MDUOp = 3'd5;
        A     = 32'h0000_DEAD;
        start = 1'b1;
      end else if (inject && n == 10) begin
        MDUOp = 3'd1;
        A     = $urandom;
        B     = $urandom;
        start = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    model_apply(op, a, b);
    chk({tag, " busy_cycles"}, 32'(n), 32'd32);
    chk({tag, " done_pulse"}, 32'(done), 32'd1);
    chk({tag, " HI"}, HI, m_hi);
    chk({tag, " LO"}, LO, m_lo);
    @(negedge clk);
    chk({tag, " done_clear"}, 32'(done), 32'd0);
    chk({tag, " busy_clear"}, 32'(busy), 32'd0);
  endtask

  // Single-edge command with no run phase (mthi/mtlo/reserved).
  task automatic quick_op(input string tag, input logic [2:0] op, input logic [31:0] a);
    @(negedge clk);
    MDUOp = op;
    A     = a;
    B     = $urandom;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_apply(op, a, 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " HI"}, HI, m_hi);
    chk({tag, " LO"}, LO, m_lo);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd0;
      3:       return 32'(32'($urandom_range(0, 20)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    m_hi   = 32'd0;
    m_lo   = 32'd0;
    reset  = 1'b1;
    start  = 1'b0;
    A      = 32'd0;
    B      = 32'd0;
    MDUOp  = 3'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset HI", HI, 32'd0);
    chk("reset LO", LO, 32'd0);

    // Directed cases.
    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("multu_max HI const", HI, 32'hFFFF_FFFE);
    chk("multu_max LO const", LO, 32'h0000_0001);
    run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
    chk("mult_neg LO const", LO, 32'hFFFF_FFF1);
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_neg LO const", LO, 32'hFFFF_FFFD);
    chk("div_neg HI const", HI, 32'hFFFF_FFFF);
    run_op("divu_7_2", 3'd3, 32'd7, 32'd2, 1'b0);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_ovf LO const", LO, 32'h8000_0000);
    quick_op("mthi", 3'd4, 32'h11);
    quick_op("mtlo", 3'd5, 32'h22);
    run_op("divu_zero", 3'd3, 32'd5, 32'd0, 1'b0);
    chk("divu_zero HI const", HI, 32'h11);
    run_op("mult_inject", 3'd0, 32'd2, 32'd3, 1'b1);
    chk("mult_inject LO const", LO, 32'd6);
    quick_op("reserved6", 3'd6, 32'hCAFE_F00D);

    // Reset mid-run aborts the divide.
    @(negedge clk);
    MDUOp = 3'd2;
    A     = 32'd100;
    B     = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort HI", HI, 32'd0);
    chk("abort LO", LO, 32'd0);
    run_op("multu_4x4", 3'd1, 32'd4, 32'd4, 1'b0);

    // Randomized commands against the model.
    for (int i = 0; i < 30; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 3'($urandom_range(0, 7));
      a  = pick_val();
      b  = pick_val();
      if (op <= 3'd3) run_op("rand_md", op, a, b, 1'($urandom_range(0, 1)));
      else            quick_op("rand_q", op, a);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
